// File: rtl/mc_seq_pkg.sv
// Shared definitions for the multicycle sequencer: state codes, opcodes, control-word layout.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package mc_seq_pkg;

    // State register encoding; also exported on state_o for debug.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_WB_ALU   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_t;

    // Fully decoded opcodes; R/I classes are matched on the top two bits.
    localparam logic [5:0] OP_LW   = 6'h20;
    localparam logic [5:0] OP_SW   = 6'h21;
    localparam logic [5:0] OP_BEQ  = 6'h30;
    localparam logic [5:0] OP_J    = 6'h31;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // Control-word bit positions (bit16..bit0).
    localparam int CW_ZERO_OR_SIGN = 16;
    localparam int CW_PC_WRITE_CND = 15;
    localparam int CW_PC_WRITE     = 14;
    localparam int CW_IOR_D        = 13;
    localparam int CW_MEM_READ     = 12;
    localparam int CW_MEM_WRITE    = 11;
    localparam int CW_MEM_TO_REG   = 10;
    localparam int CW_IR_WRITE     = 9;
    localparam int CW_PC_SRC_LSB   = 7;   // [8:7]
    localparam int CW_ALU_OP_LSB   = 5;   // [6:5]
    localparam int CW_ALU_SRCB_LSB = 3;   // [4:3]
    localparam int CW_ALU_SRCA     = 2;
    localparam int CW_REG_WRITE    = 1;
    localparam int CW_REG_DST      = 0;

    // Per-state base control words; opcode-dependent bits are patched in the decoder.
    localparam logic [16:0] CW_FETCH    = 17'h04208; // PCWrite, IRWrite, SrcB=01
    localparam logic [16:0] CW_DECODE   = 17'h00010; // SrcB=10, ALUOp=add
    localparam logic [16:0] CW_EXEC_R   = 17'h00024; // SrcA=RegA, SrcB=RegB, ALUOp=func
    localparam logic [16:0] CW_EXEC_I   = 17'h00034; // SrcA=RegA, SrcB=imm, ALUOp=func
    localparam logic [16:0] CW_WB_ALU   = 17'h00002; // RegWrite
    localparam logic [16:0] CW_MEM_ADDR = 17'h10014; // SrcA=RegA, SrcB=imm, sign-extend
    localparam logic [16:0] CW_MEM_RD   = 17'h01000; // MemRead
    localparam logic [16:0] CW_MEM_WR   = 17'h00800; // MemWrite
    localparam logic [16:0] CW_WB_MEM   = 17'h00403; // RegWrite, MemtoReg, RegDst
    localparam logic [16:0] CW_BRANCH   = 17'h080C4; // SrcA=RegA, ALUOp=sub, PCWriteCond, PCSource=01
    localparam logic [16:0] CW_JUMP     = 17'h04100; // PCWrite, PCSource=10

    function automatic logic is_rtype(input logic [5:0] op);
        return op[5:4] == 2'b00;
    endfunction

    function automatic logic is_itype(input logic [5:0] op);
        return op[5:4] == 2'b01;
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational {state, opcode} -> 17-bit datapath control word (Moore, opcode only refines fields).
// Latency: 0 cycles (pure combinational).
// Backpressure: none; follows state every cycle.
//   state     : current sequencer state
//   opcode    : IR[31:26], selects ZeroOrSign in EXEC_I and RegDst in WB_ALU
//   ctrl_word : datapath control word
module mc_ctrl_decode
    import mc_seq_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    output logic [16:0] ctrl_word
);

    always_comb begin
        ctrl_word = '0;
        unique case (state)
            ST_FETCH:    ctrl_word = CW_FETCH;
            ST_DECODE:   ctrl_word = CW_DECODE;
            ST_EXEC_R:   ctrl_word = CW_EXEC_R;
            ST_EXEC_I: begin
                ctrl_word = CW_EXEC_I;
                // opcode[3]=0 selects sign extension of the immediate
                ctrl_word[CW_ZERO_OR_SIGN] = ~opcode[3];
            end
            ST_WB_ALU: begin
                ctrl_word = CW_WB_ALU;
                // I-type writes rt, R-type writes rd
                ctrl_word[CW_REG_DST] = is_itype(opcode);
            end
            ST_MEM_ADDR: ctrl_word = CW_MEM_ADDR;
            ST_MEM_RD:   ctrl_word = CW_MEM_RD;
            ST_MEM_WR:   ctrl_word = CW_MEM_WR;
            ST_WB_MEM:   ctrl_word = CW_WB_MEM;
            ST_BRANCH:   ctrl_word = CW_BRANCH;
            ST_JUMP:     ctrl_word = CW_JUMP;
            default:     ctrl_word = '0;   // HALT and unused codes drive nothing
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Moore control FSM stepping FETCH->DECODE->EXEC/MEM->WB; counts retired instrs, sticky HALT on faults.
// Latency: R/I 4 cycles, LW 5+waits, SW 4+waits, BEQ/J 3 cycles.
// Backpressure: stalls in MEM_RD/MEM_WR until mem_ready; halts with mem_fault after MEM_TIMEOUT cycles.
//   clk, reset  : clock, synchronous active-high reset
//   opcode      : IR[31:26], stable from DECODE to end of instruction
//   mem_ready   : DMem access complete (only looked at in MEM_RD/MEM_WR)
//   ctrl_word   : datapath control word, forced to 0 during reset
//   mem_req     : DMem access in progress
//   state_o     : current state code
//   instr_count : retired instruction count (wraps)
//   halted, illegal_op, mem_fault : HALT status and sticky cause flags
module multicycle_sequencer
    import mc_seq_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output logic [16:0]          ctrl_word,
    output logic                 mem_req,
    output logic [3:0]           state_o,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic                 halted,
    output logic                 illegal_op,
    output logic                 mem_fault
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              in_mem_wait;
    logic              timed_out;
    logic              set_illegal;
    logic              set_fault;
    logic [16:0]       dec_word;

    assign in_mem_wait = (state == ST_MEM_RD) || (state == ST_MEM_WR);
    // Last allowed wait cycle; a mem_ready in this same cycle still completes the access.
    assign timed_out   = (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) && !mem_ready;

    always_comb begin
        next_state  = state;
        set_illegal = 1'b0;
        set_fault   = 1'b0;
        unique case (state)
            ST_FETCH:  next_state = ST_DECODE;
            ST_DECODE: begin
                if (is_rtype(opcode))                         next_state = ST_EXEC_R;
                else if (is_itype(opcode))                    next_state = ST_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)  next_state = ST_MEM_ADDR;
                else if (opcode == OP_BEQ)                    next_state = ST_BRANCH;
                else if (opcode == OP_J)                      next_state = ST_JUMP;
                else if (opcode == OP_HALT)                   next_state = ST_HALT;
                else begin
                    next_state  = ST_HALT;
                    set_illegal = 1'b1;
                end
            end
            ST_EXEC_R, ST_EXEC_I: next_state = ST_WB_ALU;
            ST_MEM_ADDR: next_state = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) next_state = ST_WB_MEM;
                else if (timed_out) begin
                    next_state = ST_HALT;
                    set_fault  = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready) next_state = ST_FETCH;
                else if (timed_out) begin
                    next_state = ST_HALT;
                    set_fault  = 1'b1;
                end
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP: next_state = ST_FETCH;
            ST_HALT:   next_state = ST_HALT;
            default:   next_state = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            instr_count <= '0;
            wait_cnt    <= '0;
            illegal_op  <= 1'b0;
            mem_fault   <= 1'b0;
        end else begin
            state <= next_state;
            // Only completed instructions re-enter FETCH; HALT never leaves.
            if (next_state == ST_FETCH)
                instr_count <= instr_count + CNT_WIDTH'(1);
            // Held at zero outside the wait states, so it is clear on entry.
            if (!in_mem_wait)
                wait_cnt <= '0;
            else if (!mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            illegal_op <= illegal_op | set_illegal;
            mem_fault  <= mem_fault | set_fault;
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .opcode    (opcode),
        .ctrl_word (dec_word)
    );

    assign ctrl_word = reset ? '0 : dec_word;
    assign mem_req   = !reset && in_mem_wait;
    assign state_o   = state;
    assign halted    = (state == ST_HALT);

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;
    import mc_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'h00;
    logic        mem_ready = 1'b0;
    logic [16:0] ctrl_word;
    logic        mem_req;
    logic [3:0]  state_o;
    logic [31:0] instr_count;
    logic        halted;
    logic        illegal_op;
    logic        mem_fault;

    int total = 0;
    int bad   = 0;

    multicycle_sequencer #(.CNT_WIDTH(32), .MEM_TIMEOUT(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .ctrl_word   (ctrl_word),
        .mem_req     (mem_req),
        .state_o     (state_o),
        .instr_count (instr_count),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .mem_fault   (mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        rdy;
        state_t      st;
        logic [16:0] ctrl;
        logic        req;
        logic [31:0] cnt;
        logic        hlt;
        logic        ill;
        logic        flt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic rst, input logic [5:0] op, input logic rdy,
                                input state_t st, input logic [16:0] ctrl, input logic req,
                                input logic [31:0] cnt, input logic hlt, input logic ill,
                                input logic flt);
        vec_t v;
        v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctrl = ctrl;
        v.req = req; v.cnt = cnt; v.hlt = hlt; v.ill = ill; v.flt = flt;
        return v;
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s %s got=%0h want=%0h", nm, fld, got, want);
        end
    endtask

    // Inputs change on the falling edge; outputs are compared 1ns later, before the next rising edge.
    task automatic step(input string nm, input vec_t v);
        @(negedge clk);
        reset     = v.rst;
        opcode    = v.op;
        mem_ready = v.rdy;
        #1;
        chk(nm, "state",  32'(state_o),     32'(v.st));
        chk(nm, "ctrl",   32'(ctrl_word),   32'(v.ctrl));
        chk(nm, "memreq", 32'(mem_req),     32'(v.req));
        chk(nm, "count",  instr_count,      v.cnt);
        chk(nm, "halted", 32'(halted),      32'(v.hlt));
        chk(nm, "illop",  32'(illegal_op),  32'(v.ill));
        chk(nm, "fault",  32'(mem_fault),   32'(v.flt));
    endtask

    initial begin
        // ---- main table: rst, op, rdy | state, ctrl, req, cnt, halted, illegal, fault
        tbl.push_back(mk(1, 6'h00, 0, ST_FETCH,    17'h00000, 0, 0, 0, 0, 0)); // in reset
        tbl.push_back(mk(0, 6'h02, 0, ST_FETCH,    17'h04208, 0, 0, 0, 0, 0)); // R-type
        tbl.push_back(mk(0, 6'h02, 0, ST_DECODE,   17'h00010, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h02, 0, ST_EXEC_R,   17'h00024, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h02, 0, ST_WB_ALU,   17'h00002, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h14, 0, ST_FETCH,    17'h04208, 0, 1, 0, 0, 0)); // I-type, sign
        tbl.push_back(mk(0, 6'h14, 0, ST_DECODE,   17'h00010, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h14, 0, ST_EXEC_I,   17'h10034, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h14, 0, ST_WB_ALU,   17'h00003, 0, 1, 0, 0, 0));
        tbl.push_back(mk(0, 6'h18, 0, ST_FETCH,    17'h04208, 0, 2, 0, 0, 0)); // I-type, zero
        tbl.push_back(mk(0, 6'h18, 0, ST_DECODE,   17'h00010, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 6'h18, 0, ST_EXEC_I,   17'h00034, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 6'h18, 0, ST_WB_ALU,   17'h00003, 0, 2, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_FETCH,    17'h04208, 0, 3, 0, 0, 0)); // LW, 3 waits
        tbl.push_back(mk(0, 6'h20, 0, ST_DECODE,   17'h00010, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_MEM_ADDR, 17'h10014, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_MEM_RD,   17'h01000, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_MEM_RD,   17'h01000, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_MEM_RD,   17'h01000, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 1, ST_MEM_RD,   17'h01000, 1, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h20, 0, ST_WB_MEM,   17'h00403, 0, 3, 0, 0, 0));
        tbl.push_back(mk(0, 6'h31, 0, ST_FETCH,    17'h04208, 0, 4, 0, 0, 0)); // J
        tbl.push_back(mk(0, 6'h31, 0, ST_DECODE,   17'h00010, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, 6'h31, 0, ST_JUMP,     17'h04100, 0, 4, 0, 0, 0));
        tbl.push_back(mk(0, 6'h30, 0, ST_FETCH,    17'h04208, 0, 5, 0, 0, 0)); // BEQ
        tbl.push_back(mk(0, 6'h30, 0, ST_DECODE,   17'h00010, 0, 5, 0, 0, 0));
        tbl.push_back(mk(0, 6'h30, 0, ST_BRANCH,   17'h080C4, 0, 5, 0, 0, 0));
        tbl.push_back(mk(0, 6'h21, 1, ST_FETCH,    17'h04208, 0, 6, 0, 0, 0)); // SW, rdy ignored early
        tbl.push_back(mk(0, 6'h21, 1, ST_DECODE,   17'h00010, 0, 6, 0, 0, 0));
        tbl.push_back(mk(0, 6'h21, 1, ST_MEM_ADDR, 17'h10014, 0, 6, 0, 0, 0));
        tbl.push_back(mk(0, 6'h21, 1, ST_MEM_WR,   17'h00800, 1, 6, 0, 0, 0));
        tbl.push_back(mk(0, 6'h2A, 1, ST_FETCH,    17'h04208, 0, 7, 0, 0, 0)); // illegal
        tbl.push_back(mk(0, 6'h2A, 1, ST_DECODE,   17'h00010, 0, 7, 0, 0, 0));
        tbl.push_back(mk(0, 6'h2A, 1, ST_HALT,     17'h00000, 0, 7, 1, 1, 0));
        tbl.push_back(mk(0, 6'h2A, 1, ST_HALT,     17'h00000, 0, 7, 1, 1, 0));
        tbl.push_back(mk(1, 6'h3F, 0, ST_HALT,     17'h00000, 0, 7, 1, 1, 0)); // reset from HALT
        tbl.push_back(mk(0, 6'h3F, 0, ST_FETCH,    17'h04208, 0, 0, 0, 0, 0)); // HALT opcode
        tbl.push_back(mk(0, 6'h3F, 0, ST_DECODE,   17'h00010, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 6'h3F, 0, ST_HALT,     17'h00000, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 6'h3F, 0, ST_HALT,     17'h00000, 0, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step($sformatf("tbl%0d", i), tbl[i]);

        // ---- SW where mem_ready arrives on the last allowed wait cycle: completes, no fault
        step("rw_rst", mk(1, 6'h21, 0, ST_HALT,     17'h00000, 0, 0, 1, 0, 0));
        step("rw_f",   mk(0, 6'h21, 0, ST_FETCH,    17'h04208, 0, 0, 0, 0, 0));
        step("rw_d",   mk(0, 6'h21, 0, ST_DECODE,   17'h00010, 0, 0, 0, 0, 0));
        step("rw_a",   mk(0, 6'h21, 0, ST_MEM_ADDR, 17'h10014, 0, 0, 0, 0, 0));
        for (int k = 0; k < 15; k++)
            step("rw_wait", mk(0, 6'h21, 0, ST_MEM_WR, 17'h00800, 1, 0, 0, 0, 0));
        step("rw_last", mk(0, 6'h21, 1, ST_MEM_WR,  17'h00800, 1, 0, 0, 0, 0));
        step("rw_done", mk(0, 6'h21, 0, ST_FETCH,   17'h04208, 0, 1, 0, 0, 0));

        // ---- SW with mem_ready never asserted: 16 MEM_WR cycles then HALT with mem_fault
        step("to_d",   mk(0, 6'h21, 0, ST_DECODE,   17'h00010, 0, 1, 0, 0, 0));
        step("to_a",   mk(0, 6'h21, 0, ST_MEM_ADDR, 17'h10014, 0, 1, 0, 0, 0));
        for (int k = 0; k < 16; k++)
            step("to_wait", mk(0, 6'h21, 0, ST_MEM_WR, 17'h00800, 1, 1, 0, 0, 0));
        step("to_halt", mk(0, 6'h21, 0, ST_HALT,    17'h00000, 0, 1, 1, 0, 1));
        step("to_hold", mk(0, 6'h21, 1, ST_HALT,    17'h00000, 0, 1, 1, 0, 1));

        // ---- reset during MEM_RD abandons the LW; then BEQ runs from a clean state
        step("rr_rst", mk(1, 6'h31, 0, ST_HALT,     17'h00000, 0, 1, 1, 0, 1));
        step("rr_jf",  mk(0, 6'h31, 0, ST_FETCH,    17'h04208, 0, 0, 0, 0, 0));
        step("rr_jd",  mk(0, 6'h31, 0, ST_DECODE,   17'h00010, 0, 0, 0, 0, 0));
        step("rr_jj",  mk(0, 6'h31, 0, ST_JUMP,     17'h04100, 0, 0, 0, 0, 0));
        step("rr_lf",  mk(0, 6'h20, 0, ST_FETCH,    17'h04208, 0, 1, 0, 0, 0));
        step("rr_ld",  mk(0, 6'h20, 0, ST_DECODE,   17'h00010, 0, 1, 0, 0, 0));
        step("rr_la",  mk(0, 6'h20, 0, ST_MEM_ADDR, 17'h10014, 0, 1, 0, 0, 0));
        step("rr_lr",  mk(0, 6'h20, 0, ST_MEM_RD,   17'h01000, 1, 1, 0, 0, 0));
        step("rr_in",  mk(1, 6'h20, 0, ST_MEM_RD,   17'h00000, 0, 1, 0, 0, 0));
        step("rr_bf",  mk(0, 6'h30, 1, ST_FETCH,    17'h04208, 0, 0, 0, 0, 0));
        step("rr_bd",  mk(0, 6'h30, 1, ST_DECODE,   17'h00010, 0, 0, 0, 0, 0));
        step("rr_bb",  mk(0, 6'h30, 0, ST_BRANCH,   17'h080C4, 0, 0, 0, 0, 0));
        step("rr_bx",  mk(0, 6'h00, 0, ST_FETCH,    17'h04208, 0, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
